// File: rtl/alu_cmd_issuer.sv
// Command front end for the 8-bit ALU: buffers (op, A, B) requests in a FIFO,
// issues one at a time, waits for done (with timeout) and returns a tagged response.
module alu_cmd_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic [1:0]  alu_select,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_start,
  input  logic [15:0] alu_result,
  input  logic        alu_overflow,
  input  logic        alu_negative,
  input  logic        alu_zero,
  input  logic        alu_carry_out,
  input  logic        alu_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic [1:0]  rsp_tag
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state, state_nxt;

  logic [1:0] fifo_op  [DEPTH];
  logic [7:0] fifo_a   [DEPTH];
  logic [7:0] fifo_b   [DEPTH];
  logic [1:0] fifo_tag [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [1:0]    tag_cnt;
  logic [7:0]    wait_cnt;
  logic          fifo_empty, fifo_full, push, pop;
  logic          wait_done, wait_expire;

  // Extra pointer MSB tells a wrapped (full) FIFO apart from an empty one.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == IDLE) && !fifo_empty;

  assign wait_done   = (state == WAIT) && alu_done;
  assign wait_expire = (state == WAIT) && !alu_done && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_done || wait_expire) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr[AW-1:0]]  <= cmd_op;
      fifo_a[wr_ptr[AW-1:0]]   <= cmd_a;
      fifo_b[wr_ptr[AW-1:0]]   <= cmd_b;
      fifo_tag[wr_ptr[AW-1:0]] <= tag_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tag_cnt    <= '0;
      wait_cnt   <= '0;
      alu_start  <= 1'b0;
      alu_select <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      rsp_tag    <= '0;
    end else begin
      state     <= state_nxt;
      alu_start <= pop;

      if (push) begin
        wr_ptr  <= wr_ptr + PW'(1);
        tag_cnt <= tag_cnt + 2'd1;
      end

      // Operands and tag are held from the pop until the next pop.
      if (pop) begin
        rd_ptr     <= rd_ptr + PW'(1);
        alu_select <= fifo_op[rd_ptr[AW-1:0]];
        alu_a      <= fifo_a[rd_ptr[AW-1:0]];
        alu_b      <= fifo_b[rd_ptr[AW-1:0]];
        rsp_tag    <= fifo_tag[rd_ptr[AW-1:0]];
      end

      if (state == ISSUE)
        wait_cnt <= '0;
      else if ((state == WAIT) && !alu_done)
        wait_cnt <= wait_cnt + 8'd1;

      // Done takes priority over an expiring counter in the same cycle.
      if (wait_done) begin
        rsp_valid  <= 1'b1;
        rsp_result <= alu_result;
        rsp_flags  <= {alu_overflow, alu_negative, alu_zero, alu_carry_out};
        rsp_err    <= 1'b0;
      end else if (wait_expire) begin
        rsp_valid  <= 1'b1;
        rsp_result <= '0;
        rsp_flags  <= '0;
        rsp_err    <= 1'b1;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid  <= 1'b0;
      end
    end
  end

endmodule
